// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction-fetch path: FSM states,
// PC update selection, and the default widths/step used by the PC/adder logic.
package fetch_pkg;

    localparam int FETCH_PC_W    = 64;
    localparam int FETCH_INSTR_W = 32;
    localparam int FETCH_PC_STEP = 4;

    typedef enum logic [1:0] {
        ISSUE = 2'd0,
        WAIT  = 2'd1,
        HOLD  = 2'd2
    } fetch_state_t;

    // Which value the PC register takes at the next edge.
    typedef enum logic [1:0] {
        PC_KEEP   = 2'd0,
        PC_INC    = 2'd1,
        PC_BRANCH = 2'd2
    } pc_sel_t;

endpackage

// File: rtl/fetch_timeout_cnt.sv
// Saturating wait-cycle counter for the fetch FSM; expired is high while the
// count sits at TIMEOUT-1.
module fetch_timeout_cnt #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] count;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of block ordering.
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            count <= '0;
        end else if (en && (count != LAST)) begin
            // Saturate so a branch held across the expiry cycle cannot wrap.
            count <= count + CNT_W'(1);
        end
    end

    assign expired = (count == LAST);

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, issues single-beat reads to the
// instruction memory and hands instructions to decode over valid/ready.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int              PC_W     = FETCH_PC_W,
    parameter int              INSTR_W  = FETCH_INSTR_W,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter int              PC_STEP  = FETCH_PC_STEP,
    parameter int              TIMEOUT  = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stall,
    input  logic               branch_taken,
    input  logic [PC_W-1:0]    branch_target,
    output logic               mem_rd_en,
    output logic [PC_W-1:0]    mem_rd_address,
    input  logic               mem_rdy,
    input  logic [INSTR_W-1:0] mem_data,
    output logic [INSTR_W-1:0] instr_out,
    output logic [PC_W-1:0]    instr_pc,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic               fetch_err
);

    fetch_state_t state, state_next;
    pc_sel_t      pc_sel;

    logic [PC_W-1:0] pc;
    logic            squash, squash_next;
    logic            capture, clr_valid;
    logic            cnt_clr, cnt_en, cnt_expired;

    fetch_timeout_cnt #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk     (clk),
        .reset   (reset),
        .clr     (cnt_clr),
        .en      (cnt_en),
        .expired (cnt_expired)
    );

    assign mem_rd_address = pc;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ISSUE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every signal driven here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_next  = state;
        pc_sel      = PC_KEEP;
        squash_next = squash;
        capture     = 1'b0;
        clr_valid   = 1'b0;
        cnt_clr     = 1'b0;
        cnt_en      = 1'b0;
        fetch_err   = 1'b0;
        mem_rd_en   = (state == ISSUE) && !stall && !branch_taken && !reset;

        case (state)
            ISSUE: begin
                if (branch_taken) begin
                    pc_sel = PC_BRANCH;
                end else if (mem_rd_en) begin
                    state_next = WAIT;
                    cnt_clr    = 1'b1;
                end
            end

            WAIT: begin
                cnt_en = 1'b1;
                if (branch_taken) begin
                    // A response arriving alongside the redirect belongs to the
                    // old path, so it completes the squashed fetch immediately.
                    pc_sel = PC_BRANCH;
                    if (mem_rdy) begin
                        squash_next = 1'b0;
                        state_next  = ISSUE;
                    end else begin
                        squash_next = 1'b1;
                    end
                end else if (mem_rdy) begin
                    if (squash) begin
                        squash_next = 1'b0;
                        state_next  = ISSUE;
                    end else begin
                        capture    = 1'b1;
                        pc_sel     = PC_INC;
                        state_next = HOLD;
                    end
                end else if (cnt_expired) begin
                    // PC is left alone so the next ISSUE retries the same fetch.
                    fetch_err   = 1'b1;
                    squash_next = 1'b0;
                    state_next  = ISSUE;
                end
            end

            HOLD: begin
                if (branch_taken) begin
                    pc_sel     = PC_BRANCH;
                    clr_valid  = 1'b1;
                    state_next = ISSUE;
                end else if (instr_valid && instr_ready) begin
                    clr_valid  = 1'b1;
                    state_next = ISSUE;
                end
            end

            default: begin
                state_next = ISSUE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc          <= RESET_PC;
            squash      <= 1'b0;
            instr_valid <= 1'b0;
            instr_out   <= '0;
            instr_pc    <= '0;
        end else begin
            squash <= squash_next;

            case (pc_sel)
                PC_INC:    pc <= pc + PC_W'(PC_STEP);
                PC_BRANCH: pc <= branch_target & ~PC_W'(3);
                default:   pc <= pc;
            endcase

            if (capture) begin
                instr_out   <= mem_data;
                instr_pc    <= pc;
                instr_valid <= 1'b1;
            end else if (clr_valid) begin
                instr_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: a per-cycle vector table for the main flow
// plus hand-written sequences for timeout, mid-flight reset and PC wrap.
module tb_fetch_ctrl;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        branch_taken;
    logic [63:0] branch_target;
    logic        mem_rd_en;
    logic [63:0] mem_rd_address;
    logic        mem_rdy;
    logic [31:0] mem_data;
    logic [31:0] instr_out;
    logic [63:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        fetch_err;

    int checks = 0;
    int errors = 0;

    fetch_ctrl #(
        .PC_W     (64),
        .INSTR_W  (32),
        .RESET_PC (64'h0),
        .PC_STEP  (4),
        .TIMEOUT  (16)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .branch_taken   (branch_taken),
        .branch_target  (branch_target),
        .mem_rd_en      (mem_rd_en),
        .mem_rd_address (mem_rd_address),
        .mem_rdy        (mem_rdy),
        .mem_data       (mem_data),
        .instr_out      (instr_out),
        .instr_pc       (instr_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .fetch_err      (fetch_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        stall;
        logic        br;
        logic [63:0] tgt;
        logic        rdy;
        logic [31:0] data;
        logic        ready;
        logic        en;
        logic [63:0] addr;
        logic        valid;
        logic [31:0] instr;
        logic [63:0] ipc;
        logic        err;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t v(input int s, input int b, input logic [63:0] t,
                               input int r, input logic [31:0] d, input int rd,
                               input int en, input logic [63:0] addr, input int val,
                               input logic [31:0] instr, input logic [63:0] ipc,
                               input int err);
        vec_t x;
        x.stall = s[0];   x.br    = b[0];   x.tgt   = t;
        x.rdy   = r[0];   x.data  = d;      x.ready = rd[0];
        x.en    = en[0];  x.addr  = addr;   x.valid = val[0];
        x.instr = instr;  x.ipc   = ipc;    x.err   = err[0];
        return x;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input int s, input int b, input logic [63:0] t,
                         input int r, input logic [31:0] d, input int rd);
        stall         = s[0];
        branch_taken  = b[0];
        branch_target = t;
        mem_rdy       = r[0];
        mem_data      = d;
        instr_ready   = rd[0];
    endtask

    initial begin
        reset = 1'b1;
        drive(0, 0, 64'h0, 0, 32'h0, 1);

        // Columns: stall br target rdy data ready | rd_en addr valid instr instr_pc err
        vecs.push_back(v(0,0,64'h0,0,32'h0,1,        1,64'h0,   0,32'h0,64'h0,0));
        vecs.push_back(v(0,0,64'h0,1,32'hA0,1,       0,64'h0,   0,32'h0,64'h0,0));
        vecs.push_back(v(0,0,64'h0,0,32'h0,1,        0,64'h4,   1,32'hA0,64'h0,0));
        vecs.push_back(v(0,0,64'h0,0,32'h0,1,        1,64'h4,   0,32'hA0,64'h0,0));
        vecs.push_back(v(0,0,64'h0,1,32'hA1,1,       0,64'h4,   0,32'hA0,64'h0,0));
        vecs.push_back(v(0,0,64'h0,0,32'h0,1,        0,64'h8,   1,32'hA1,64'h4,0));
        vecs.push_back(v(0,0,64'h0,0,32'h0,1,        1,64'h8,   0,32'hA1,64'h4,0));
        vecs.push_back(v(0,0,64'h0,1,32'hA2,1,       0,64'h8,   0,32'hA1,64'h4,0));
        vecs.push_back(v(0,0,64'h0,0,32'h0,1,        0,64'hC,   1,32'hA2,64'h8,0));
        vecs.push_back(v(0,0,64'h0,0,32'h0,1,        1,64'hC,   0,32'hA2,64'h8,0));
        vecs.push_back(v(0,0,64'h0,1,32'hA3,1,       0,64'hC,   0,32'hA2,64'h8,0));
        vecs.push_back(v(0,0,64'h0,0,32'h0,1,        0,64'h10,  1,32'hA3,64'hC,0));
        for (int i = 0; i < 4; i++)
            vecs.push_back(v(1,0,64'h0,0,32'h0,1,    0,64'h10,  0,32'hA3,64'hC,0));
        vecs.push_back(v(0,0,64'h0,0,32'h0,1,        1,64'h10,  0,32'hA3,64'hC,0));
        vecs.push_back(v(0,0,64'h0,1,32'hB0,1,       0,64'h10,  0,32'hA3,64'hC,0));
        vecs.push_back(v(0,0,64'h0,0,32'h0,0,        0,64'h14,  1,32'hB0,64'h10,0));
        vecs.push_back(v(0,0,64'h0,0,32'h0,0,        0,64'h14,  1,32'hB0,64'h10,0));
        vecs.push_back(v(0,0,64'h0,1,32'hBAD0,0,     0,64'h14,  1,32'hB0,64'h10,0));
        vecs.push_back(v(0,0,64'h0,0,32'h0,0,        0,64'h14,  1,32'hB0,64'h10,0));
        vecs.push_back(v(0,0,64'h0,0,32'h0,0,        0,64'h14,  1,32'hB0,64'h10,0));
        vecs.push_back(v(0,0,64'h0,0,32'h0,1,        0,64'h14,  1,32'hB0,64'h10,0));
        vecs.push_back(v(0,0,64'h0,0,32'h0,1,        1,64'h14,  0,32'hB0,64'h10,0));
        vecs.push_back(v(0,1,64'h1003,0,32'h0,1,     0,64'h14,  0,32'hB0,64'h10,0));
        vecs.push_back(v(0,0,64'h0,0,32'h0,1,        0,64'h1000,0,32'hB0,64'h10,0));
        vecs.push_back(v(0,0,64'h0,1,32'hDEADBEEF,1, 0,64'h1000,0,32'hB0,64'h10,0));
        vecs.push_back(v(0,0,64'h0,0,32'h0,1,        1,64'h1000,0,32'hB0,64'h10,0));
        vecs.push_back(v(0,1,64'h2000,1,32'h11111111,1, 0,64'h1000,0,32'hB0,64'h10,0));
        vecs.push_back(v(0,0,64'h0,0,32'h0,1,        1,64'h2000,0,32'hB0,64'h10,0));
        vecs.push_back(v(0,0,64'h0,1,32'hC0,1,       0,64'h2000,0,32'hB0,64'h10,0));
        vecs.push_back(v(0,1,64'h3000,0,32'h0,1,     0,64'h2004,1,32'hC0,64'h2000,0));
        vecs.push_back(v(0,1,64'h4000,0,32'h0,1,     0,64'h3000,0,32'hC0,64'h2000,0));
        vecs.push_back(v(0,0,64'h0,0,32'h0,1,        1,64'h4000,0,32'hC0,64'h2000,0));

        // Reset state, observed while reset is still asserted.
        @(posedge clk);
        @(negedge clk);
        #1;
        check("reset rd_en", 64'(mem_rd_en), 64'h0);
        check("reset addr",  mem_rd_address, 64'h0);
        check("reset valid", 64'(instr_valid), 64'h0);
        check("reset instr", 64'(instr_out), 64'h0);
        check("reset ipc",   instr_pc, 64'h0);
        check("reset err",   64'(fetch_err), 64'h0);

        foreach (vecs[i]) begin
            @(negedge clk);
            reset = 1'b0;
            drive(int'(vecs[i].stall), int'(vecs[i].br), vecs[i].tgt,
                  int'(vecs[i].rdy), vecs[i].data, int'(vecs[i].ready));
            #1;
            check($sformatf("v%0d rd_en", i), 64'(mem_rd_en), 64'(vecs[i].en));
            check($sformatf("v%0d addr", i),  mem_rd_address, vecs[i].addr);
            check($sformatf("v%0d valid", i), 64'(instr_valid), 64'(vecs[i].valid));
            check($sformatf("v%0d instr", i), 64'(instr_out), 64'(vecs[i].instr));
            check($sformatf("v%0d ipc", i),   instr_pc, vecs[i].ipc);
            check($sformatf("v%0d err", i),   64'(fetch_err), 64'(vecs[i].err));
        end

        // Timeout: request issued in the last vector; withhold mem_rdy.
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            drive(0, 0, 64'h0, 0, 32'h0, 1);
            #1;
            check($sformatf("tmo c%0d err", k), 64'(fetch_err), (k == 16) ? 64'h1 : 64'h0);
            check($sformatf("tmo c%0d rd_en", k), 64'(mem_rd_en), 64'h0);
        end
        @(negedge clk);
        #1;
        check("retry rd_en", 64'(mem_rd_en), 64'h1);
        check("retry addr",  mem_rd_address, 64'h4000);
        check("retry err",   64'(fetch_err), 64'h0);

        // Reset while in WAIT, then a late response that must be ignored.
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("rst wait rd_en", 64'(mem_rd_en), 64'h0);
        @(negedge clk);
        reset = 1'b0;
        drive(1, 0, 64'h0, 1, 32'hFF, 1);
        #1;
        check("late rd_en", 64'(mem_rd_en), 64'h0);
        check("late addr",  mem_rd_address, 64'h0);
        check("late valid", 64'(instr_valid), 64'h0);
        check("late instr", 64'(instr_out), 64'h0);
        check("late ipc",   instr_pc, 64'h0);
        @(negedge clk);
        drive(0, 0, 64'h0, 0, 32'h0, 1);
        #1;
        check("post rst rd_en", 64'(mem_rd_en), 64'h1);
        check("post rst valid", 64'(instr_valid), 64'h0);

        // PC wrap: redirect to the top word, fetch it, PC rolls to zero.
        @(negedge clk);
        drive(0, 1, 64'hFFFF_FFFF_FFFF_FFFF, 0, 32'h0, 1);
        @(negedge clk);
        drive(0, 0, 64'h0, 1, 32'h5555, 1);
        #1;
        check("wrap tgt addr", mem_rd_address, 64'hFFFF_FFFF_FFFF_FFFC);
        @(negedge clk);
        drive(0, 0, 64'h0, 0, 32'h0, 1);
        #1;
        check("wrap rd_en",  64'(mem_rd_en), 64'h1);
        check("wrap valid0", 64'(instr_valid), 64'h0);
        @(negedge clk);
        drive(0, 0, 64'h0, 1, 32'h7777, 1);
        @(negedge clk);
        drive(0, 0, 64'h0, 0, 32'h0, 1);
        #1;
        check("wrap valid", 64'(instr_valid), 64'h1);
        check("wrap instr", 64'(instr_out), 64'h7777);
        check("wrap ipc",   instr_pc, 64'hFFFF_FFFF_FFFF_FFFC);
        check("wrap addr",  mem_rd_address, 64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
